timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 115 +++++++++++
 tb/tb_timer_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ctrl
//  Description : Start/stop run timer with one-shot and periodic modes,
//                terminal-count pulse and one-cycle completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================

module timer_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic             start_ack,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             start_ack_q;
    logic             busy_q;
    logic             done_q;
    logic             at_limit;

    assign at_limit = (count_q == limit_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            mode_q      <= 1'b0;
            start_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (start && !stop) begin
                        state_q     <= LOAD;
                        start_ack_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    limit_q     <= limit;
                    mode_q      <= mode;
                    count_q     <= '0;
                    start_ack_q <= 1'b0;
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks terminal count so a stop on the tc cycle never completes
                    if (stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (at_limit) begin
                        if (mode_q) begin
                            count_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // stop gates tc combinationally so an abort on the terminal cycle shows no pulse
    assign tc        = (state_q == RUN) && at_limit && !stop;
    assign start_ack = start_ack_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_ctrl
//  Description : Scenario bench for timer_ctrl with an expected-output queue.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_timer_ctrl;

    localparam int         W      = 5;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] limit;
    logic         start_ack;
    logic         busy;
    logic [W-1:0] count;
    logic         tc;
    logic         done;
    logic [1:0]   state;

    typedef struct packed {
        logic [1:0]   st;
        logic [W-1:0] cnt;
        logic         tc;
        logic         dn;
        logic         ack;
        logic         bsy;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    timer_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .limit     (limit),
        .start_ack (start_ack),
        .busy      (busy),
        .count     (count),
        .tc        (tc),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void push(input logic [1:0] st, input int cnt,
                                 input logic t, input logic d,
                                 input logic a, input logic b);
        exp_t e;
        e.st  = st;
        e.cnt = cnt[W-1:0];
        e.tc  = t;
        e.dn  = d;
        e.ack = a;
        e.bsy = b;
        sb.push_back(e);
    endfunction

    function automatic exp_t observe();
        return exp_t'({state, count, tc, done, start_ack, busy});
    endfunction

    task automatic set_in(input logic s, input logic p, input logic m, input int l);
        start = s;
        stop  = p;
        mode  = m;
        limit = l[W-1:0];
    endtask

    task automatic test_reset();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 5);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_oneshot();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c <= 4; c++) push(S_RUN, c, c == 4, 0, 0, 1);
        push(S_DONE, 4, 0, 1, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(i == 0, 1'b0, 1'b0, 4);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL oneshot[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_periodic();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 32; c++) push(S_RUN, c, c == 31, 0, 0, 1);
        for (int c = 0; c <= 3; c++) push(S_RUN, c, 0, 0, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(i == 0, i == 69, 1'b1, 31);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL periodic[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c <= 5; c++) push(S_RUN, c, 0, 0, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(i == 0, i == 7, 1'b0, 10);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL abort[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c <= 3; c++) push(S_RUN, c, 0, 0, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(i == 0 || i == 2 || i == 9, i == 0 || i == 7 || i == 10, 1'b0, 3);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL simultaneous[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_limit_zero();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c < 4; c++) push(S_RUN, 0, 1, 0, 0, 1);
        push(S_RUN, 0, 0, 0, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        push(S_RUN, 0, 1, 0, 0, 1);
        push(S_DONE, 0, 0, 1, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            set_in(i == 0 || i == 8, i == 6, i < 8, 0);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL limit0[%0d] observed %b expected %b", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        exp_t o, e;
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c <= 3; c++) push(S_RUN, c, 0, 0, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_IDLE, 0, 0, 0, 0, 0);
        push(S_LOAD, 0, 0, 0, 1, 1);
        for (int c = 0; c <= 4; c++) push(S_RUN, c, c == 4, 0, 0, 1);
        push(S_DONE, 4, 0, 1, 0, 1);
        push(S_IDLE, 0, 0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            if (i == 6) reset = 1'b0;
            set_in(i == 0 || i == 6, 1'b0, i >= 8, (i < 6) ? 10 : (i < 8) ? 4 : 7);
            #1;
            o = observe(); e = sb.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL asyncrst[%0d] observed %b expected %b", i, o, e);
            end
            if (i == 5) begin
                #1 reset = 1'b1;
                #1;
                o = observe(); e = sb.pop_front(); vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL asyncrst_midcycle observed %b expected %b", o, e);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 0);
        test_reset();
        test_oneshot();
        test_periodic();
        test_abort();
        test_back_to_back();
        test_limit_zero();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
